toggle_activity_monitor: RTL
============================

// Module: toggle_activity_monitor
// PURPOSE
//   Sits directly downstream of a power-experiment sub-circuit. Samples that
//   sub-circuit's primary inputs and output, e.g. {n_9,n_4,n_3,n_2,n_1}, as one
//   vector.
//   Counts per-bit 0<->1 transitions over a fixed window of consecutive valid
//   samples, then streams one count per bit out through a valid/ready port.
//   The counts feed switching-activity-based power estimation.
// PARAMETERS
//   NUM_SIG   5   width of the sampled signal vector
//   WIN_LOG2  8   window = 2**WIN_LOG2 transitions, i.e. WIN+1 valid samples
//   CNT_W     16  per-bit counter width; counters saturate at 2**CNT_W-1
// PORTS
//   clk        in   1                   single clock, rising edge
//   rst        in   1                   async, active-high reset
//   start      in   1                   1-cycle pulse; begin a measurement
//   sig_valid  in   1                   sig_in holds a sample this cycle
//   sig_in     in   NUM_SIG             sampled sub-circuit inputs/output
//   busy       out  1                   1 in any state other than IDLE
//   res_valid  out  1                   res_index/res_count are valid
//   res_ready  in   1                   consumer accepts the result
//   res_index  out  $clog2(NUM_SIG)     bit number of the reported count
//   res_count  out  CNT_W               toggle count of bit res_index
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, res_valid=0, res_index=0, res_count=0;
//     all counters, prev register and window counter cleared. Async assert;
//     release is synchronised externally.
//   FSM states: IDLE -> ARM -> RUN -> DRAIN -> IDLE.
//   IDLE:  start=1 -> ARM, counters cleared on the same edge.
//          start=0 -> stay.
//   ARM:   first cycle with sig_valid=1 -> load prev<=sig_in, go to RUN.
//          Nothing is counted in ARM.
//   RUN:   each sig_valid=1 cycle: diff=sig_in^prev; cnt[i]+=diff[i]
//          (saturating); prev<=sig_in; win_cnt+=1.
//          sig_valid=0 cycles hold everything (gaps are allowed).
//          Transition to DRAIN is taken on the edge that accepts the
//          2**WIN_LOG2-th valid sample, which is itself counted.
//   DRAIN: res_valid=1 from the first DRAIN cycle.
//          res_index starts at 0; res_count=cnt[res_index].
//          Transfer occurs on the edge where res_valid & res_ready = 1:
//          index+1, or on index NUM_SIG-1 -> IDLE with res_valid=0 next cycle.
//          res_index/res_count are held stable while res_valid & !res_ready.
//          sig_in and sig_valid are ignored in DRAIN.
//   Latency: last window sample -> res_valid=1 on the next cycle.
//            Minimum DRAIN length is NUM_SIG cycles, with res_ready tied high.
//   start is ignored in ARM, RUN and DRAIN; a measurement never restarts
//     mid-flight.
//   Saturation: cnt[i] stays at 2**CNT_W-1 once reached; it does not wrap.
//   win_cnt has WIN_LOG2+1 bits and does not wrap within a window.
//   rst in any state aborts the measurement. No partial result is emitted;
//     res_valid drops immediately.
//   Counts reflect consecutive valid samples only; a gap does not count as a
//     transition.
// TESTING  (NUM_SIG=5, WIN_LOG2=2, CNT_W=16 unless noted)
//   1. start; 5 valid samples of 5'b00000 -> DRAIN emits idx0..4, all count 0.
//   2. start; bit0 alternates 0,1,0,1,0, other bits 0 -> idx0=4, idx1..4=0.
//   3. Same as test 2 with sig_valid=0 inserted between samples -> identical
//      counts; busy stays 1 throughout.
//   4. res_ready held low 3 cycles at idx2 -> idx2/count stable; then
//      idx3, idx4; then IDLE, busy=0.
//   5. CNT_W=2, WIN_LOG2=3; bit4 toggles on every sample -> idx4 count=3
//      (saturated, not 0).
//   6. rst pulse mid-RUN -> res_valid=0, busy=0 at once. A new start plus
//      test-1 stimulus yields all counts 0.

Source files
------------

// File: rtl/toggle_activity_monitor_if.sv
// Handshake and data bundle between a toggle activity monitor and its driver/consumer.
// The master side drives start, samples and res_ready; the slave side is the monitor.
interface toggle_activity_monitor_if #(
    parameter int NUM_SIG = 5,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;

    logic               start;
    logic               sig_valid;
    logic [NUM_SIG-1:0] sig_in;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [IDX_W-1:0]   res_index;
    logic [CNT_W-1:0]   res_count;

    modport master (
        output start, sig_valid, sig_in, res_ready,
        input  busy, res_valid, res_index, res_count
    );

    modport slave (
        input  start, sig_valid, sig_in, res_ready,
        output busy, res_valid, res_index, res_count
    );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Counts per-bit 0<->1 transitions over a window of consecutive valid samples,
// then streams one saturating count per bit through a valid/ready result port.
module toggle_activity_monitor #(
    parameter int NUM_SIG  = 5,
    parameter int WIN_LOG2 = 8,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    toggle_activity_monitor_if.slave mon
);
    localparam int IDX_W = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;
    localparam int WIN_W = WIN_LOG2 + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((2 ** WIN_LOG2) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SIG - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t             state_q;
    logic               busy_q;
    logic               res_valid_q;
    logic [IDX_W-1:0]   res_index_q;
    logic [CNT_W-1:0]   res_count_q;
    logic [NUM_SIG-1:0] prev_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [CNT_W-1:0]   cnt_q [NUM_SIG];

    logic [NUM_SIG-1:0] diff_d;
    logic [CNT_W-1:0]   cnt_d [NUM_SIG];
    logic [IDX_W-1:0]   next_idx_d;
    logic [CNT_W-1:0]   next_cnt_d;
    logic               win_last_d;

    always_comb begin
        diff_d     = mon.sig_in ^ prev_q;
        win_last_d = (win_cnt_q == WIN_LAST);
        next_idx_d = res_index_q + 1'b1;
        next_cnt_d = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            cnt_d[i] = (diff_d[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + 1'b1 : cnt_q[i];
            if (next_idx_d == IDX_W'(i)) begin
                next_cnt_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_count_q <= '0;
            prev_q      <= '0;
            win_cnt_q   <= '0;
            for (int i = 0; i < NUM_SIG; i++) cnt_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mon.start) begin
                        state_q   <= ARM;
                        busy_q    <= 1'b1;
                        prev_q    <= '0;
                        win_cnt_q <= '0;
                        for (int i = 0; i < NUM_SIG; i++) cnt_q[i] <= '0;
                    end
                end
                ARM: begin
                    // First valid sample only establishes the reference value.
                    if (mon.sig_valid) begin
                        prev_q  <= mon.sig_in;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (mon.sig_valid) begin
                        for (int i = 0; i < NUM_SIG; i++) cnt_q[i] <= cnt_d[i];
                        prev_q    <= mon.sig_in;
                        win_cnt_q <= win_cnt_q + 1'b1;
                        if (win_last_d) begin
                            state_q     <= DRAIN;
                            res_valid_q <= 1'b1;
                            res_index_q <= '0;
                            res_count_q <= cnt_d[0];
                        end
                    end
                end
                DRAIN: begin
                    if (mon.res_ready) begin
                        if (res_index_q == IDX_LAST) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            res_valid_q <= 1'b0;
                            res_index_q <= '0;
                            res_count_q <= '0;
                        end else begin
                            res_index_q <= next_idx_d;
                            res_count_q <= next_cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mon.busy      = busy_q;
    assign mon.res_valid = res_valid_q;
    assign mon.res_index = res_index_q;
    assign mon.res_count = res_count_q;
endmodule
